// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver driven by a 16x oversampling tick.
// The line is synchronised into the clock domain first. The start bit is
// confirmed at its middle, and every later bit is sampled 16 ticks after
// the previous sample. A low stop bit reports a framing error and then
// parks the receiver until the line returns high.
module uart_rx (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_16x_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t     state_q, state_d;
    logic       rx_meta_q, rx_meta_d;
    logic       rx_s_q, rx_s_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       frame_err_q, frame_err_d;

    // Register all receiver state; the synchroniser idles at the line's idle level
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            tick_cnt_q  <= 4'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic: the FSM and its counters advance only on tick cycles
    always_comb begin
        state_d     = state_q;
        rx_meta_d   = rx_i;
        rx_s_d      = rx_meta_q;
        tick_cnt_d  = tick_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        if (tick_16x_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rx_s_q) begin
                        state_d    = ST_START;
                        tick_cnt_d = 4'd0;
                    end
                end
                ST_START: begin
                    if (tick_cnt_q == 4'd7) begin
                        tick_cnt_d = 4'd0;
                        bit_idx_d  = 3'd0;
                        state_d    = rx_s_q ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
                ST_DATA: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        shift_d[bit_idx_q] = rx_s_q;
                        if (bit_idx_q == 3'd7) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick_cnt_q == 4'd15) begin
                        tick_cnt_d = 4'd0;
                        if (rx_s_q) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameters: none; frame format fixed at 8N1, 16x oversampling.
REQ-002 clk_i  input  1  system clock, all state on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 tick_16x_i  input  1  single-cycle enable pulse from the baud generator, once per 1/16 bit period.
REQ-005 rx_i  input  1  asynchronous serial line, idle high.
REQ-006 data_o  output  8  last correctly framed byte, LSB received first.
REQ-007 valid_o  output  1  one-cycle pulse: data_o has just been updated.
REQ-008 frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 busy_o  output  1  high in every state except IDLE.

Function
REQ-010 rx_i SHALL pass through a 2-flop synchronizer; both flops reset to 1; all decisions use the second flop (rx_s).
REQ-011 State machine SHALL have states IDLE, START, DATA, STOP, BREAK.
REQ-012 All state and counter updates other than the synchronizer and output pulse clearing SHALL occur only on cycles with tick_16x_i=1.
REQ-013 IDLE: on a tick with rx_s=0 go to START and clear the 4-bit tick counter; otherwise stay.
REQ-014 START: increment the tick counter each tick; on the tick where the counter equals 7 (the 8th tick, mid start bit), sample rx_s: 0 -> DATA with counter and bit index cleared; 1 -> IDLE (glitch rejected, no output pulse).
REQ-015 DATA: on the tick where the counter equals 15, sample rx_s into bit position equal to the bit index (LSB first), wrap the counter to 0, and increment the bit index; the sample at bit index 7 SHALL go to STOP.
REQ-016 STOP: on the tick where the counter equals 15, sample rx_s: 1 -> load the shift register into data_o, pulse valid_o, go to IDLE; 0 -> pulse frame_err_o, leave data_o unchanged, go to BREAK.
REQ-017 BREAK: stay until a tick with rx_s=1, then go to IDLE; no new start bit is detected while in BREAK.
REQ-018 valid_o and frame_err_o SHALL each be high for exactly one clk_i cycle, the cycle after the deciding tick edge, and SHALL never be high together.
REQ-019 data_o SHALL hold its value between valid_o pulses, including across glitches, framing errors and BREAK.
REQ-020 The tick counter SHALL be 4 bits and the bit index 3 bits; no counter wraps except as stated in REQ-015.
REQ-021 Ticks arriving on consecutive cycles SHALL each be counted; ticks are never required to be spaced.
REQ-022 A new start bit SHALL be detectable on the first tick after returning to IDLE, with no dead time.
REQ-023 busy_o SHALL be a registered or state-decoded output with no combinational path from rx_i.

Reset
REQ-024 While rst_i=0: state=IDLE, counters=0, shift register=0x00, data_o=0x00, valid_o=0, frame_err_o=0, busy_o=0, synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately with no output pulse; after release the block SHALL wait in IDLE for a new falling edge sampled on a tick.
REQ-026 Reset release SHALL not itself cause start detection while rx_i is high.

Verification
REQ-027 Frame 0x55 at 16 ticks/bit, stop=1 -> data_o=0x55, valid_o one pulse, frame_err_o=0, busy_o low afterwards.
REQ-028 Back-to-back frames 0xA5 then 0x3C, no idle gap -> two valid_o pulses, data_o=0xA5 then 0x3C.
REQ-029 rx_i low for 5 ticks then high -> return to IDLE, no pulses, data_o unchanged.
REQ-030 Frame 0xFF with stop bit held low for 3 bit times -> one frame_err_o pulse, data_o unchanged, busy_o high until rx high, no start detected during break.
REQ-031 rst_i asserted during data bit 4 of frame 0x81, released, then frame 0x7E sent -> only 0x7E reported, data_o=0x00 until then.
REQ-032 Frame 0x96 with a 2-tick high glitch centred away from each mid-bit sample -> data_o=0x96, valid_o one pulse.
